// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side blocks.
package uart_pkg;

  // Receiver-enable sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rx_state_t;

  // Parity check modes used by the receiver datapath.
  localparam logic [2:0] CHECK_NONE   = 3'd0;
  localparam logic [2:0] CHECK_EVEN   = 3'd1;
  localparam logic [2:0] CHECK_ODD    = 3'd2;
  localparam logic [2:0] CHECK_FIXED0 = 3'd3;
  localparam logic [2:0] CHECK_FIXED1 = 3'd4;

  // System clocks per bit period.
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Output byte stream of the receive controller.
// Handshake: a transfer happens on a rising clk edge where m_valid and
// m_ready are both 1. m_valid never depends on m_ready; m_data/m_perr are
// only meaningful while m_valid is 1 and stay stable until accepted.
interface uart_rx_ctrl_if;
  logic [7:0] m_data;
  logic       m_perr;
  logic       m_valid;
  logic       m_ready;

  modport master (output m_data, output m_perr, output m_valid, input m_ready);
  modport slave  (input m_data, input m_perr, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// Generic synchronous FIFO with occupancy. Write while full is accepted only
// when a read happens in the same cycle; read of an empty FIFO is ignored.
module uart_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             rd_ok;
  logic             wr_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  // Storage, power-of-two wrapping pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: baud tick generation, receiver enable sequencing,
// byte buffering with parity tag, sticky overflow and parity-error count.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        clr,
  input  logic                        rx_clk_en,
  output logic                        rx_clk,
  output logic                        rx_en,
  input  logic [7:0]                  rx_data,
  input  logic                        rx_data_valid,
  input  logic                        rx_check_flag,
  uart_rx_ctrl_if.master              m_if,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow,
  output logic [7:0]                  err_cnt,
  output rx_state_t                   fsm_state
);
  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CW       = $clog2(BAUD_DIV);

  logic [CW-1:0] cnt;
  logic          first;
  rx_state_t     state_q;
  rx_state_t     state_d;
  logic          full;
  logic          empty;
  logic          rd;
  logic [8:0]    head;

  assign fsm_state = state_q;

  // Baud tick: first tick lands mid start-bit, later ones a full bit apart.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      first  <= 1'b1;
      rx_clk <= 1'b0;
    end else if (!rx_clk_en) begin
      cnt    <= '0;
      first  <= 1'b1;
      rx_clk <= 1'b0;
    end else if (first && cnt == CW'(BAUD_DIV/2 - 1)) begin
      cnt    <= '0;
      first  <= 1'b0;
      rx_clk <= 1'b1;
    end else if (!first && cnt == CW'(BAUD_DIV - 1)) begin
      cnt    <= '0;
      rx_clk <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      rx_clk <= 1'b0;
    end
  end

  // Enable sequencer next state: a frame in flight (rx_clk_en) holds DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enable) state_d = ST_RUN;
      ST_RUN:   if (!enable) state_d = rx_clk_en ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: begin
        if (enable)          state_d = ST_RUN;
        else if (!rx_clk_en) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register; rx_en is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rx_en   <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_en   <= (state_d != ST_IDLE);
    end
  end

  assign rd            = m_if.m_valid && m_if.m_ready;
  assign m_if.m_valid  = !empty;
  assign m_if.m_data   = head[7:0];
  assign m_if.m_perr   = head[8];

  uart_rx_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (rx_data_valid),
    .wr_data ({rx_check_flag, rx_data}),
    .rd_en   (rd),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Sticky overflow and saturating error count; a coincident event beats clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      err_cnt  <= 8'd0;
    end else begin
      if (rx_data_valid && full && !rd) overflow <= 1'b1;
      else if (clr)                     overflow <= 1'b0;
      if (rx_data_valid && rx_check_flag) begin
        if (clr)                   err_cnt <= 8'd1;
        else if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end else if (clr) begin
        err_cnt <= 8'd0;
      end
    end
  end
endmodule
